nfu_2_pipe: RTL and testbench
=============================

# nfu_2_pipe

NFU-2 stage of the neural functional unit: sits directly downstream of the NFU-1 multiplier array and consumes its Tn×Tn product matrix each valid beat. For each of Tn output neurons it reduces the Tn products through a pipelined adder tree, then accumulates the tree sums across successive input tiles, framed by first/last flags. It presents Tn finished neuron sums to the downstream NFU-3 stage with a one-cycle valid pulse.

## Interface
- N, 16, fixed-point word width (two's complement)
- Tn, 16, inputs per tile and output neurons per tile; power of two, ≥2
- TREE_STAGES, $clog2(Tn), adder-tree pipeline depth (derived, not overridden)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_valid  input  1  product beat valid this cycle
- i_first  input  1  beat is first tile of an output-neuron group (qualified by i_valid)
- i_last  input  1  beat is last tile of the group (qualified by i_valid)
- i_products  input  N*Tn*Tn  NFU-1 products, row-major: word (i*Tn+j) = input i × synapse for neuron j
- o_valid  output  1  o_results valid, single-cycle pulse
- o_results  output  N*Tn  neuron j sum in bits [(j+1)*N-1 : j*N]
- o_proto_err  output  1  sticky framing-error flag

## Operation
- Tree: for each neuron j, sum over i of word (i*Tn+j); binary tree, one register level per add level; valid/first/last travel with data.
- Accumulator stage FSM, states IDLE, ACCUM; evaluated when the tree-output valid is high:
  - IDLE, first: acc ← sum; → ACCUM (or stay IDLE if also last).
  - ACCUM, not first: acc ← acc + sum.
  - last (any state, after the above): o_results ← new acc value, o_valid=1, → IDLE.
  - first && last same beat: o_results ← sum directly, acc unaffected beyond overwrite.
  - IDLE, not first: treated as first; set o_proto_err.
  - ACCUM, first: discard old acc, restart with sum; set o_proto_err.
- No tree-output valid: acc, state, o_results hold; o_valid=0.
- Arithmetic: every add is N-bit two's complement, result N bits; overflow behaviour per Configuration.
- No backpressure: a beat is accepted every cycle i_valid is high; downstream must sink every o_valid pulse.
- o_proto_err cleared only by rst.

## Timing
- Reset values: o_valid=0, o_results=0, o_proto_err=0, acc=0, state=IDLE, all pipeline valids=0.
- Reset mid-operation discards all in-flight beats and partial sums; first beat after deassert must carry i_first.
- Latency: beat with i_last at cycle t → o_valid at t+TREE_STAGES+1 (5 for Tn=16).
- Throughput: one beat per cycle; back-to-back groups with no bubble allowed (last at t, first at t+1).
- o_results holds its value until the next o_valid.

## Configuration
- NFU2_SATURATE_EN defined: every tree add and accumulator add saturates to [-2^(N-1), 2^(N-1)-1].
- Undefined: all adds wrap modulo 2^N. Default build leaves it undefined.

## Structure
- Package nfu_pkg: default N/Tn constants, FSM state enum, add function (saturating or wrapping under the macro) shared by tree and accumulator.
- Sub-module nfu_2_add_tree: one Tn-input pipelined tree with valid sideband; instantiated Tn times (one per neuron). FSM and accumulators stay in nfu_2_pipe.

## Test plan
- Reset values: assert rst mid-stream → all outputs 0 immediately; no o_valid after release until a new framed group completes.
- Single tile, Tn=16: all products 1, first=last=1 → o_valid after 5 cycles, every neuron = 16.
- Three-tile group: per-tile products for neuron j = j, tiles first/–/last → each neuron = 48*j, one o_valid pulse 5 cycles after last beat.
- Back-to-back groups with no bubble: group A (1 tile, sums 10) then group B (2 tiles, sums 20+30) → o_valid pulses with 10 then 50, no cross-contamination.
- Overflow: 16 products of 0x4000 → wrap result 0x0000 without macro; 0x7FFF with NFU2_SATURATE_EN; negative case 16×0xC000 → 0x0000 / 0x8000.
- Framing errors: non-first beat from IDLE, then first while ACCUM → o_proto_err set and held; sums restart as specified (second group's result excludes discarded partial).

Source files
------------

// File: rtl/nfu_pkg.sv
// NFU-2 shared types and the adder used by both the tree and the accumulator.
// Combinational helpers only; no latency, no backpressure.
// NFU2_SATURATE_EN selects saturating adds; left undefined, adds wrap modulo 2^N.
package nfu_pkg;

  localparam int NFU_N  = 16;
  localparam int NFU_TN = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } meta_t;

  // Operands arrive sign-extended; the result is brought back into the w-bit range.
  function automatic longint nfu_add(input longint a, input longint b, input int w);
    longint hi;
    longint lo;
    longint s;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    s  = a + b;
`ifdef NFU2_SATURATE_EN
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
`else
    if (s > hi) s = s - (hi - lo + 1);
    else if (s < lo) s = s + (hi - lo + 1);
`endif
    return s;
  endfunction

endpackage

// File: rtl/nfu_2_add_tree.sv
// One Tn-input pipelined binary adder tree with first/last/valid sideband.
// Latency $clog2(Tn) cycles, one register per add level; accepts a beat every cycle.
// No backpressure. Add mode follows NFU2_SATURATE_EN via nfu_add.
module nfu_2_add_tree
  import nfu_pkg::*;
#(
  parameter int N  = NFU_N,
  parameter int Tn = NFU_TN
) (
  input  logic            clk,
  input  logic            rst,
  input  meta_t           i_meta,
  input  logic [Tn*N-1:0] i_data,
  output meta_t           o_meta,
  output logic [N-1:0]    o_sum
);

  localparam int TREE_STAGES = $clog2(Tn);

  // Heap-indexed nodes: node n adds children 2n and 2n+1; indices >= Tn are input words.
  for (genvar n = 1; n < Tn; n++) begin : g_node
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    if (2 * n >= Tn) begin : g_leaf
      assign a = i_data[(2*n-Tn)*N +: N];
      assign b = i_data[(2*n+1-Tn)*N +: N];
    end else begin : g_inner
      assign a = g_node[2*n].q;
      assign b = g_node[2*n+1].q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else     q <= N'(nfu_add(longint'($signed(a)), longint'($signed(b)), N));
    end
  end

  meta_t meta_q [TREE_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < TREE_STAGES; s++) meta_q[s] <= '0;
    end else begin
      meta_q[0] <= i_meta;
      for (int s = 1; s < TREE_STAGES; s++) meta_q[s] <= meta_q[s-1];
    end
  end

  assign o_sum  = g_node[1].q;
  assign o_meta = meta_q[TREE_STAGES-1];

endmodule

// File: rtl/nfu_2_pipe.sv
// NFU-2: per-neuron adder trees feeding a framed accumulator, results to NFU-3.
// Latency $clog2(Tn)+1 cycles from the last beat to the o_valid pulse; one beat per cycle.
// No backpressure: every valid beat is taken. NFU2_SATURATE_EN selects saturating adds.
module nfu_2_pipe
  import nfu_pkg::*;
#(
  parameter int N  = NFU_N,
  parameter int Tn = NFU_TN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic               i_first,
  input  logic               i_last,
  input  logic [N*Tn*Tn-1:0] i_products,
  output logic               o_valid,
  output logic [N*Tn-1:0]    o_results,
  output logic               o_proto_err
);

  meta_t                 in_meta;
  meta_t                 tree_meta [Tn];
  logic [Tn-1:0][N-1:0]  tree_sum;

  assign in_meta = '{vld: i_valid, first: i_first, last: i_last};

  for (genvar j = 0; j < Tn; j++) begin : g_neuron
    logic [Tn*N-1:0] col;
    for (genvar i = 0; i < Tn; i++) begin : g_gather
      assign col[i*N +: N] = i_products[(i*Tn+j)*N +: N];
    end
    nfu_2_add_tree #(.N(N), .Tn(Tn)) u_tree (
      .clk    (clk),
      .rst    (rst),
      .i_meta (in_meta),
      .i_data (col),
      .o_meta (tree_meta[j]),
      .o_sum  (tree_sum[j])
    );
  end

  // Every tree carries an identical sideband copy.
  logic t_vld, t_first, t_last;
  always_comb begin
    t_vld   = 1'b1;
    t_first = 1'b1;
    t_last  = 1'b1;
    for (int j = 0; j < Tn; j++) begin
      t_vld   = t_vld   & tree_meta[j].vld;
      t_first = t_first & tree_meta[j].first;
      t_last  = t_last  & tree_meta[j].last;
    end
  end

  state_t               state_q, state_d;
  logic [Tn-1:0][N-1:0] acc_q, acc_d, acc_new, res_q, res_d;
  logic                 vld_d, err_d, restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (t_vld) state_d = t_last ? IDLE : ACCUM;
  end

  // A non-first beat in IDLE and a first beat in ACCUM both restart the sum.
  always_comb begin
    restart = (state_q == IDLE) || t_first;
    acc_new = '0;
    acc_d   = acc_q;
    res_d   = res_q;
    vld_d   = 1'b0;
    err_d   = o_proto_err;
    for (int j = 0; j < Tn; j++) begin
      acc_new[j] = restart ? tree_sum[j]
                 : N'(nfu_add(longint'($signed(acc_q[j])), longint'($signed(tree_sum[j])), N));
    end
    if (t_vld) begin
      acc_d = acc_new;
      if ((state_q == IDLE) != t_first) err_d = 1'b1;
      if (t_last) begin
        res_d = acc_new;
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      res_q       <= '0;
      o_valid     <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_q       <= res_d;
      o_valid     <= vld_d;
      o_proto_err <= err_d;
    end
  end

  assign o_results = res_q;

endmodule

// File: tb/tb_nfu_2_pipe.sv
// Scoreboard bench for nfu_2_pipe (N=16, Tn=16): expected sums and arrival cycles are
// queued as beats are driven and checked when o_valid pulses.
module tb_nfu_2_pipe;

  localparam int N  = 16;
  localparam int TN = 16;
  localparam int LAT = 5;

  typedef logic [N*TN*TN-1:0] prod_t;
  typedef logic [N*TN-1:0]    res_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  i_valid = 1'b0, i_first = 1'b0, i_last = 1'b0;
  prod_t i_products = '0;
  logic  o_valid, o_proto_err;
  res_t  o_results;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  res_t exp_q [$];
  int   cyc_q [$];

  nfu_2_pipe #(.N(N), .Tn(TN)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_first(i_first), .i_last(i_last),
    .i_products(i_products), .o_valid(o_valid), .o_results(o_results), .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: every word = v; mode 1: word(i,j) = j; mode 2: row 0 = v, rest 0.
  function automatic prod_t mk(input int mode, input logic [N-1:0] v);
    prod_t p;
    logic [N-1:0] w;
    p = '0;
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++) begin
        w = (mode == 0) ? v : (mode == 1) ? N'(j) : ((i == 0) ? v : '0);
        p[(i*TN+j)*N +: N] = w;
      end
    return p;
  endfunction

  function automatic res_t exp_all(input logic [N-1:0] v);
    res_t r;
    for (int j = 0; j < TN; j++) r[j*N +: N] = v;
    return r;
  endfunction

  function automatic res_t exp_lin(input int m);
    res_t r;
    for (int j = 0; j < TN; j++) r[j*N +: N] = N'(m * j);
    return r;
  endfunction

  // Entered at posedge+1; presents one beat for a cycle and returns at the next posedge+1.
  task automatic beat(input logic f, input logic l, input prod_t p, input res_t e);
    i_valid = 1'b1; i_first = f; i_last = l; i_products = p;
    if (l) begin
      exp_q.push_back(e);
      cyc_q.push_back(cyc + LAT);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (o_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", o_valid); end
    compared++; if (o_results !== '0) begin mismatched++; $display("FAIL reset_results got %h want 0", o_results); end
    compared++; if (o_proto_err !== 1'b0) begin mismatched++; $display("FAIL reset_err got %b want 0", o_proto_err); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    res_t e; int c;
    @(posedge clk); #1;
    beat(1'b1, 1'b1, mk(0, 16'd1), exp_all(16'd16));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL single_extra got %h want none", o_results); end
        else begin
          e = exp_q.pop_front(); c = cyc_q.pop_front();
          if (o_results !== e) begin mismatched++; $display("FAIL single_data got %h want %h", o_results, e); end
          compared++; if (cyc !== c) begin mismatched++; $display("FAIL single_latency got %0d want %0d", cyc, c); end
        end
      end
    end
    if (exp_q.size() != 0) begin compared++; mismatched++; $display("FAIL single_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); cyc_q.delete(); end
  endtask

  task automatic test_multi_tile;
    res_t e; int c;
    @(posedge clk); #1;
    beat(1'b1, 1'b0, mk(1, '0), '0);
    beat(1'b0, 1'b0, mk(1, '0), '0);
    beat(1'b0, 1'b1, mk(1, '0), exp_lin(48));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL multi_extra got %h want none", o_results); end
        else begin
          e = exp_q.pop_front(); c = cyc_q.pop_front();
          if (o_results !== e) begin mismatched++; $display("FAIL multi_data got %h want %h", o_results, e); end
          compared++; if (cyc !== c) begin mismatched++; $display("FAIL multi_latency got %0d want %0d", cyc, c); end
        end
      end
    end
    if (exp_q.size() != 0) begin compared++; mismatched++; $display("FAIL multi_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); cyc_q.delete(); end
  endtask

  task automatic test_back_to_back;
    res_t e; int c;
    @(posedge clk); #1;
    beat(1'b1, 1'b1, mk(2, 16'd10), exp_all(16'd10));
    beat(1'b1, 1'b0, mk(2, 16'd20), '0);
    beat(1'b0, 1'b1, mk(2, 16'd30), exp_all(16'd50));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL b2b_extra got %h want none", o_results); end
        else begin
          e = exp_q.pop_front(); c = cyc_q.pop_front();
          if (o_results !== e) begin mismatched++; $display("FAIL b2b_data got %h want %h", o_results, e); end
          compared++; if (cyc !== c) begin mismatched++; $display("FAIL b2b_latency got %0d want %0d", cyc, c); end
        end
      end
    end
    if (exp_q.size() != 0) begin compared++; mismatched++; $display("FAIL b2b_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); cyc_q.delete(); end
  endtask

  task automatic test_overflow;
    res_t e; int c;
    logic [N-1:0] pos_exp, neg_exp;
`ifdef NFU2_SATURATE_EN
    pos_exp = 16'h7FFF; neg_exp = 16'h8000;
`else
    pos_exp = 16'h0000; neg_exp = 16'h0000;
`endif
    @(posedge clk); #1;
    beat(1'b1, 1'b1, mk(0, 16'h4000), exp_all(pos_exp));
    beat(1'b1, 1'b1, mk(0, 16'hC000), exp_all(neg_exp));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL ovf_extra got %h want none", o_results); end
        else begin
          e = exp_q.pop_front(); c = cyc_q.pop_front();
          if (o_results !== e) begin mismatched++; $display("FAIL ovf_data got %h want %h", o_results, e); end
          compared++; if (cyc !== c) begin mismatched++; $display("FAIL ovf_latency got %0d want %0d", cyc, c); end
        end
      end
    end
    if (exp_q.size() != 0) begin compared++; mismatched++; $display("FAIL ovf_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); cyc_q.delete(); end
  endtask

  task automatic test_framing;
    res_t e; int c;
    compared++; if (o_proto_err !== 1'b0) begin mismatched++; $display("FAIL err_clean got %b want 0", o_proto_err); end
    @(posedge clk); #1;
    beat(1'b0, 1'b0, mk(2, 16'd5), '0);
    beat(1'b1, 1'b0, mk(2, 16'd7), '0);
    beat(1'b0, 1'b1, mk(2, 16'd3), exp_all(16'd10));
    beat(1'b1, 1'b1, mk(2, 16'd4), exp_all(16'd4));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL frame_extra got %h want none", o_results); end
        else begin
          e = exp_q.pop_front(); c = cyc_q.pop_front();
          if (o_results !== e) begin mismatched++; $display("FAIL frame_data got %h want %h", o_results, e); end
          compared++; if (cyc !== c) begin mismatched++; $display("FAIL frame_latency got %0d want %0d", cyc, c); end
        end
      end
    end
    if (exp_q.size() != 0) begin compared++; mismatched++; $display("FAIL frame_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); cyc_q.delete(); end
    compared++; if (o_proto_err !== 1'b1) begin mismatched++; $display("FAIL err_sticky got %b want 1", o_proto_err); end
  endtask

  task automatic test_reset_midstream;
    res_t e; int c; int pulses;
    @(posedge clk); #1;
    i_valid = 1'b1; i_first = 1'b1; i_last = 1'b0; i_products = mk(0, 16'd1);
    @(posedge clk); #1;
    i_first = 1'b0; i_last = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    compared++; if (o_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got %b want 0", o_valid); end
    compared++; if (o_results !== '0) begin mismatched++; $display("FAIL midrst_results got %h want 0", o_results); end
    compared++; if (o_proto_err !== 1'b0) begin mismatched++; $display("FAIL midrst_err got %b want 0", o_proto_err); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    compared++; if (pulses !== 0) begin mismatched++; $display("FAIL midrst_stale got %0d pulses want 0", pulses); end
    @(posedge clk); #1;
    beat(1'b1, 1'b1, mk(0, 16'd2), exp_all(16'd32));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_valid) begin
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL midrst_extra got %h want none", o_results); end
        else begin
          e = exp_q.pop_front(); c = cyc_q.pop_front();
          if (o_results !== e) begin mismatched++; $display("FAIL midrst_data got %h want %h", o_results, e); end
          compared++; if (cyc !== c) begin mismatched++; $display("FAIL midrst_latency got %0d want %0d", cyc, c); end
        end
      end
    end
    if (exp_q.size() != 0) begin compared++; mismatched++; $display("FAIL midrst_timeout got %0d pending want 0", exp_q.size()); exp_q.delete(); cyc_q.delete(); end
    compared++; if (o_proto_err !== 1'b0) begin mismatched++; $display("FAIL midrst_err_after got %b want 0", o_proto_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_tile();
    test_back_to_back();
    test_overflow();
    test_framing();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
